// File: rtl/return_address_stack.sv
// Circular return-address stack for JAL/JR target prediction.
// On overflow the oldest entry is overwritten. Top_Addr/Top_Valid come from registers only.
module return_address_stack #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 32,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              Push,
  input  logic [ADDR_W-1:0] Push_Addr,
  input  logic              Pop,
  output logic [ADDR_W-1:0] Top_Addr,
  output logic              Top_Valid,
  output logic [PTR_W:0]    Count,
  output logic              Overflow,
  output logic              Underflow
);

  localparam logic [PTR_W-1:0] TOS_RST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL    = (PTR_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] entry_q [DEPTH];
  logic [ADDR_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0]  tos_q, tos_d, tos_inc, tos_dec;
  logic [PTR_W:0]    count_q, count_d;
  logic              ovf_q, ovf_d, unf_q, unf_d;

  // Pointer arithmetic wraps naturally because DEPTH == 2**PTR_W.
  assign tos_inc = tos_q + PTR_W'(1);
  assign tos_dec = tos_q - PTR_W'(1);

  always_comb begin
    entry_d = entry_q;
    tos_d   = tos_q;
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (Flush) begin
      count_d = '0;
      tos_d   = TOS_RST;
    end else if (Push && Pop && (count_q != '0)) begin
      entry_d[tos_q] = Push_Addr;
    end else if (Push) begin
      tos_d            = tos_inc;
      entry_d[tos_inc] = Push_Addr;
      if (count_q == FULL) ovf_d = 1'b1;
      else                 count_d = count_q + 1'b1;
    end else if (Pop) begin
      if (count_q != '0) begin
        tos_d   = tos_dec;
        count_d = count_q - 1'b1;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      tos_q   <= TOS_RST;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      entry_q <= entry_d;
      tos_q   <= tos_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign Top_Valid = (count_q != '0);
  assign Top_Addr  = Top_Valid ? entry_q[tos_q] : '0;
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign Underflow = unf_q;

endmodule

// File: tb/tb_return_address_stack.sv
// Scoreboard bench for return_address_stack: a queue-based LIFO model predicts
// the outputs one edge ahead; directed scenarios plus a long random run.
module tb_return_address_stack;

  localparam int DEPTH = 8;

  logic        clk, reset, Flush, Push, Pop;
  logic [31:0] Push_Addr, Top_Addr;
  logic        Top_Valid, Overflow, Underflow;
  logic [3:0]  Count;

  return_address_stack #(.DEPTH(DEPTH), .ADDR_W(32), .PTR_W(3)) dut (
    .clk(clk), .reset(reset), .Flush(Flush), .Push(Push), .Push_Addr(Push_Addr),
    .Pop(Pop), .Top_Addr(Top_Addr), .Top_Valid(Top_Valid), .Count(Count),
    .Overflow(Overflow), .Underflow(Underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        valid;
    logic [3:0]  cnt;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mq[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: SV queue, newest at the back, oldest dropped on overflow.
  task automatic model(input logic f, input logic pu, input logic po, input logic [31:0] a);
    exp_t e;
    e.ovf = 1'b0;
    e.unf = 1'b0;
    if (f) begin
      mq.delete();
    end else if (pu && po && mq.size() > 0) begin
      mq[mq.size()-1] = a;
    end else if (pu) begin
      mq.push_back(a);
      if (mq.size() > DEPTH) begin
        void'(mq.pop_front());
        e.ovf = 1'b1;
      end
    end else if (po) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else e.unf = 1'b1;
    end
    e.cnt   = 4'(mq.size());
    e.valid = (mq.size() > 0);
    e.addr  = (mq.size() > 0) ? mq[mq.size()-1] : 32'h0;
    sb.push_back(e);
  endtask

  task automatic compare_out();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    check("top_addr",  Top_Addr,  e.addr);
    check("top_valid", 32'(Top_Valid), 32'(e.valid));
    check("count",     32'(Count),     32'(e.cnt));
    check("overflow",  32'(Overflow),  32'(e.ovf));
    check("underflow", 32'(Underflow), 32'(e.unf));
  endtask

  // Called at posedge+1; drives one cycle of stimulus and checks the result.
  task automatic step(input logic f, input logic pu, input logic po, input logic [31:0] a);
    Flush = f; Push = pu; Pop = po; Push_Addr = a;
    model(f, pu, po, a);
    @(posedge clk); #1;
    Flush = 1'b0; Push = 1'b0; Pop = 1'b0;
    compare_out();
  endtask

  initial begin
    reset = 1'b1; Flush = 1'b0; Push = 1'b0; Pop = 1'b0; Push_Addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(Count), 32'd0);
    check("rst_valid", 32'(Top_Valid), 32'd0);
    check("rst_addr",  Top_Addr, 32'd0);
    check("rst_flags", 32'({Overflow, Underflow}), 32'd0);
    reset = 1'b0;

    // Basic push/pop
    step(0, 1, 0, 32'h100);
    step(0, 1, 0, 32'h200);
    step(0, 1, 0, 32'h300);
    check("t1_top", Top_Addr, 32'h300);
    check("t1_cnt", 32'(Count), 32'd3);
    step(0, 0, 1, 0);
    check("t1_pop1", Top_Addr, 32'h200);
    step(0, 0, 1, 0);
    check("t1_pop2", Top_Addr, 32'h100);
    step(0, 0, 1, 0);
    check("t1_empty", 32'({Top_Valid, Top_Addr != 0}), 32'd0);

    // Overflow then drain to underflow
    for (int i = 1; i <= 9; i++) step(0, 1, 0, 32'(i * 16));
    check("t2_ovf", 32'(Overflow), 32'd1);
    check("t2_cnt", 32'(Count), 32'd8);
    step(0, 0, 0, 0);
    check("t2_ovf_pulse", 32'(Overflow), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("t2_drain_top", Top_Addr, 32'(('h90) - i * 16));
      step(0, 0, 1, 0);
    end
    step(0, 0, 1, 0);
    check("t2_unf", 32'(Underflow), 32'd1);
    check("t2_unf_cnt", 32'(Count), 32'd0);
    step(0, 0, 1, 0);
    check("t2_unf_b2b", 32'(Underflow), 32'd1);

    // Simultaneous push+pop
    step(0, 1, 0, 32'h30);
    step(0, 1, 0, 32'h40);
    step(0, 1, 1, 32'h55);
    check("t3_replace", Top_Addr, 32'h55);
    check("t3_cnt", 32'(Count), 32'd2);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 1, 1, 32'h66);
    check("t3_empty_pp_cnt", 32'(Count), 32'd1);
    check("t3_empty_pp_unf", 32'(Underflow), 32'd0);
    check("t3_empty_pp_top", Top_Addr, 32'h66);

    // Flush beats push
    for (int i = 0; i < 4; i++) step(0, 1, 0, 32'(32'h1000 + i));
    step(1, 1, 0, 32'hDEAD);
    check("t4_flush_cnt", 32'(Count), 32'd0);
    check("t4_flush_vld", 32'(Top_Valid), 32'd0);
    step(0, 1, 0, 32'h77);
    check("t4_after", Top_Addr, 32'h77);

    // Asynchronous reset mid-cycle with Count=4
    for (int i = 0; i < 3; i++) step(0, 1, 0, 32'(32'h2000 + i));
    check("t5_pre_cnt", 32'(Count), 32'd4);
    #2 reset = 1'b1;
    #1;
    check("t5_async_cnt", 32'(Count), 32'd0);
    check("t5_async_vld", 32'(Top_Valid), 32'd0);
    check("t5_async_top", Top_Addr, 32'd0);
    #1 reset = 1'b0;
    mq.delete();
    step(0, 0, 0, 0);
    step(0, 1, 0, 32'h88);

    // Random traffic against the model
    for (int i = 0; i < 10000; i++) begin
      logic f, pu, po;
      f  = ($urandom_range(0, 63) == 0);
      pu = $urandom_range(0, 1) == 1;
      po = $urandom_range(0, 2) == 0;
      step(f, pu, po, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
